bird_datapath: RTL and testbench

//  Datapath downstream of the bird control FSM. Holds the bird's vertical position and applies start/rise/fall commands.
//  On each draw request it erases the old sprite and plots the new one through the VGA adapter pixel port.

---
 rtl/bird_pkg.sv | 18 +
 rtl/bird_datapath_sprite_scanner.sv | 31 +++
 rtl/bird_datapath.sv | 153 +++++++++++++++
 tb/tb_bird_datapath.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird sprite datapath.
package bird_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UPDATE,
      S_ERASE,
      S_DRAW,
      S_DONE
   } state_t;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   localparam logic [2:0] COLOUR_BIRD = 3'b110;
   localparam logic [2:0] COLOUR_BG   = 3'b011;

endpackage

// File: rtl/bird_datapath_sprite_scanner.sv
// Square sprite scan counter: walks dx fastest, then dy; wraps after N pixels.
module sprite_scanner
   import bird_pkg::*;
#(
   parameter int unsigned SIZE_LOG2 = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 i_clear,
   input  logic                 i_en,
   output logic [SIZE_LOG2-1:0] o_dx,
   output logic [SIZE_LOG2-1:0] o_dy,
   output logic                 o_last
);

   localparam int unsigned CW = 2 * SIZE_LOG2;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!resetn || i_clear)
         r_cnt <= '0;
      else if (i_en)
         r_cnt <= r_cnt + CW'(1);
   end

   assign o_dx   = r_cnt[SIZE_LOG2-1:0];
   assign o_dy   = r_cnt[CW-1:SIZE_LOG2];
   assign o_last = &r_cnt;

endmodule

// File: rtl/bird_datapath.sv
// Bird position register plus erase/redraw sequencer driving the VGA pixel port.
module bird_datapath
   import bird_pkg::*;
#(
   parameter logic [7:0]  BIRD_X      = 8'd40,
   parameter int unsigned SIZE_LOG2   = 2,
   parameter logic [6:0]  Y_INIT      = 7'd56,
   parameter logic [6:0]  Y_MIN       = 7'd0,
   parameter logic [6:0]  Y_MAX       = 7'd116,
   parameter logic [6:0]  RISE_STEP   = 7'd2,
   parameter logic [6:0]  FALL_STEP   = 7'd1,
   parameter logic [6:0]  HIGH_LIMIT  = 7'd10,
   parameter logic [2:0]  BIRD_COLOUR = COLOUR_BIRD,
   parameter logic [2:0]  BG_COLOUR   = COLOUR_BG
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       rise,
   input  logic       fall,
   input  logic       draw_req,
   output logic       busy,
   output logic       draw_done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic [6:0] bird_y,
   output logic       touched,
   output logic       too_high
);

   state_t r_state, w_state_next;

   logic [6:0] r_bird_y, r_old_y;
   logic       r_touched, r_last, r_plot, r_busy, r_done;
   logic [7:0] r_vga_x;
   logic [6:0] r_vga_y;
   logic [2:0] r_colour;

   logic [SIZE_LOG2-1:0] w_dx, w_dy;
   logic                 w_last, w_scan_en, w_scan_clear;
   logic [7:0]           w_y8, w_rise_lim, w_fall8;
   logic [6:0]           w_new_y, w_base_y, w_pix_y;
   logic [7:0]           w_pix_x;
   logic                 w_new_touched, w_gen_erase, w_gen_draw;

   assign w_scan_en    = (r_state == S_UPDATE) || (r_state == S_ERASE) || (r_state == S_DRAW);
   assign w_scan_clear = (r_state == S_IDLE);

   sprite_scanner #(.SIZE_LOG2(SIZE_LOG2)) u_scan (
      .clk     (clk),
      .resetn  (resetn),
      .i_clear (w_scan_clear),
      .i_en    (w_scan_en),
      .o_dx    (w_dx),
      .o_dy    (w_dy),
      .o_last  (w_last)
   );

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:   if (draw_req) w_state_next = S_UPDATE;
         S_UPDATE: w_state_next = S_ERASE;
         S_ERASE:  if (r_last) w_state_next = S_DRAW;
         S_DRAW:   if (r_last) w_state_next = S_DONE;
         S_DONE:   w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   assign w_y8       = {1'b0, r_bird_y};
   assign w_rise_lim = {1'b0, Y_MIN} + {1'b0, RISE_STEP};
   assign w_fall8    = w_y8 + {1'b0, FALL_STEP};

   always_comb begin
      w_new_y       = r_bird_y;
      w_new_touched = r_touched;
      if (start) begin
         w_new_y       = Y_INIT;
         w_new_touched = 1'b0;
      end else if (rise) begin
         if (w_y8 < w_rise_lim) begin
            w_new_y       = Y_MIN;
            w_new_touched = 1'b1;
         end else begin
            w_new_y       = r_bird_y - RISE_STEP;
            w_new_touched = 1'b0;
         end
      end else if (fall) begin
         if (w_fall8 >= {1'b0, Y_MAX}) begin
            w_new_y       = Y_MAX;
            w_new_touched = 1'b1;
         end else begin
            w_new_y       = w_fall8[6:0];
            w_new_touched = 1'b0;
         end
      end
   end

   // Pixel registers are loaded one cycle ahead of the state that shows them:
   // UPDATE loads the first erase pixel, the last ERASE cycle loads the first draw pixel.
   assign w_gen_erase = (r_state == S_UPDATE) || ((r_state == S_ERASE) && !r_last);
   assign w_gen_draw  = ((r_state == S_ERASE) && r_last) || ((r_state == S_DRAW) && !r_last);
   assign w_base_y    = (w_gen_draw || (r_state == S_UPDATE)) ? r_bird_y : r_old_y;
   assign w_pix_x     = BIRD_X + {{(8 - SIZE_LOG2){1'b0}}, w_dx};
   assign w_pix_y     = w_base_y + {{(7 - SIZE_LOG2){1'b0}}, w_dy};

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_bird_y  <= Y_INIT;
         r_old_y   <= Y_INIT;
         r_touched <= 1'b0;
         r_last    <= 1'b0;
         r_plot    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_vga_x   <= '0;
         r_vga_y   <= '0;
         r_colour  <= '0;
      end else begin
         r_state <= w_state_next;
         r_last  <= w_last && w_scan_en;
         r_busy  <= (w_state_next == S_UPDATE) || (w_state_next == S_ERASE) ||
                    (w_state_next == S_DRAW);
         r_done  <= (w_state_next == S_DONE);
         if (r_state == S_UPDATE) begin
            r_old_y   <= r_bird_y;
            r_bird_y  <= w_new_y;
            r_touched <= w_new_touched;
         end
         r_plot <= w_gen_erase || w_gen_draw;
         if (w_gen_erase || w_gen_draw) begin
            r_vga_x  <= w_pix_x;
            r_vga_y  <= w_pix_y;
            r_colour <= w_gen_draw ? BIRD_COLOUR : BG_COLOUR;
         end
      end
   end

   assign busy       = r_busy;
   assign draw_done  = r_done;
   assign plot       = r_plot;
   assign vga_x      = r_vga_x;
   assign vga_y      = r_vga_y;
   assign vga_colour = r_colour;
   assign bird_y     = r_bird_y;
   assign touched    = r_touched;
   assign too_high   = (r_bird_y <= HIGH_LIMIT);

endmodule

// File: tb/tb_bird_datapath.sv
// Directed bench for bird_datapath with a pixel scoreboard checked on every plot.
module tb_bird_datapath;

   logic       clk = 1'b0;
   logic       resetn, start, rise, fall, draw_req;
   logic       busy, draw_done, plot, touched, too_high;
   logic [7:0] vga_x;
   logic [6:0] vga_y, bird_y;
   logic [2:0] vga_colour;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   pix_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [6:0] m_y;

   bird_datapath dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .rise       (rise),
      .fall       (fall),
      .draw_req   (draw_req),
      .busy       (busy),
      .draw_done  (draw_done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .plot       (plot),
      .bird_y     (bird_y),
      .touched    (touched),
      .too_high   (too_high)
   );

   always #5 clk = ~clk;

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_draw(input logic s, input logic r, input logic f,
                           input logic [6:0] exp_y, input logic exp_t);
      pix_t p;
      for (int dy = 0; dy < 4; dy++)
         for (int dx = 0; dx < 4; dx++) begin
            p.x = 8'(40 + dx); p.y = 7'(m_y + 7'(dy)); p.c = 3'b011;
            q.push_back(p);
         end
      for (int dy = 0; dy < 4; dy++)
         for (int dx = 0; dx < 4; dx++) begin
            p.x = 8'(40 + dx); p.y = 7'(exp_y + 7'(dy)); p.c = 3'b110;
            q.push_back(p);
         end
      start = s; rise = r; fall = f; draw_req = 1'b1;
      cyc;
      draw_req = 1'b0;
      chk("update_busy", busy, 1);
      chk("update_plot", plot, 0);
      for (int i = 1; i <= 32; i++) begin
         cyc;
         chk("scan_plot", plot, 1);
         chk("scan_done", draw_done, 0);
         if (q.size() > 0) begin
            p = q.pop_front();
            chk("pix_x", vga_x, p.x);
            chk("pix_y", vga_y, p.y);
            chk("pix_colour", vga_colour, p.c);
         end
      end
      cyc;
      chk("done_pulse", draw_done, 1);
      chk("done_busy", busy, 0);
      chk("done_plot", plot, 0);
      chk("sb_empty", q.size(), 0);
      chk("bird_y", bird_y, exp_y);
      chk("touched", touched, exp_t);
      chk("too_high", too_high, (exp_y <= 7'd10));
      chk("hold_x", vga_x, 43);
      chk("hold_y", vga_y, 7'(exp_y + 7'd3));
      chk("hold_colour", vga_colour, 3'b110);
      m_y = exp_y;
      start = 1'b0; rise = 1'b0; fall = 1'b0;
      cyc;
      chk("idle_done", draw_done, 0);
   endtask

   initial begin
      int plots, dones;
      resetn = 1'b0; start = 1'b0; rise = 1'b0; fall = 1'b0; draw_req = 1'b0;
      m_y = 7'd56;
      cyc; cyc;
      chk("rst_bird_y", bird_y, 56);
      chk("rst_touched", touched, 0);
      chk("rst_plot", plot, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", draw_done, 0);
      chk("rst_vga_x", vga_x, 0);
      chk("rst_vga_y", vga_y, 0);
      chk("rst_colour", vga_colour, 0);
      chk("rst_too_high", too_high, 0);
      resetn = 1'b1;
      cyc;

      run_draw(1, 0, 0, 56, 0);
      run_draw(0, 1, 0, 54, 0);
      run_draw(0, 0, 1, 55, 0);
      for (int k = 0; k < 22; k++) run_draw(0, 1, 0, 7'(m_y - 7'd2), 0);
      chk("reach_11", bird_y, 11);
      run_draw(0, 1, 0, 9, 0);
      for (int k = 0; k < 4; k++) run_draw(0, 1, 0, 7'(m_y - 7'd2), 0);
      run_draw(0, 1, 0, 0, 1);
      run_draw(0, 1, 0, 0, 1);
      run_draw(0, 0, 0, 0, 1);
      run_draw(1, 1, 1, 56, 0);
      run_draw(0, 1, 1, 54, 0);
      for (int k = 0; k < 61; k++) run_draw(0, 0, 1, 7'(m_y + 7'd1), 0);
      chk("reach_115", bird_y, 115);
      run_draw(0, 0, 1, 116, 1);
      run_draw(0, 0, 1, 116, 1);
      run_draw(0, 0, 0, 116, 1);

      // draw_req pulsed mid-ERASE must be ignored
      plots = 0; dones = 0;
      start = 1'b1;
      for (int i = 0; i < 70; i++) begin
         draw_req = (i == 0) || (i == 6);
         cyc;
         if (i == 6) chk("mid_erase_busy", busy, 1);
         if (plot === 1'b1) plots++;
         if (draw_done === 1'b1) dones++;
      end
      draw_req = 1'b0; start = 1'b0;
      chk("mid_erase_plots", plots, 32);
      chk("mid_erase_dones", dones, 1);
      chk("mid_erase_bird_y", bird_y, 56);
      m_y = 7'd56;

      // request in the DONE cycle is dropped, the next cycle's is accepted
      start = 1'b1; draw_req = 1'b1;
      cyc;
      draw_req = 1'b0;
      for (int i = 0; i < 33; i++) cyc;
      chk("done_cycle_pulse", draw_done, 1);
      draw_req = 1'b1;
      cyc;
      chk("done_req_ignored", busy, 0);
      cyc;
      draw_req = 1'b0;
      chk("next_req_accepted", busy, 1);
      for (int i = 0; i < 33; i++) cyc;
      chk("next_req_done", draw_done, 1);
      start = 1'b0;
      cyc;

      // reset in the middle of DRAW
      run_draw(0, 1, 0, 54, 0);
      fall = 1'b1; draw_req = 1'b1;
      cyc;
      draw_req = 1'b0;
      for (int i = 0; i < 20; i++) cyc;
      chk("pre_reset_plot", plot, 1);
      resetn = 1'b0;
      cyc;
      chk("reset_plot", plot, 0);
      chk("reset_bird_y", bird_y, 56);
      chk("reset_busy", busy, 0);
      chk("reset_touched", touched, 0);
      resetn = 1'b1; fall = 1'b0;
      plots = 0; dones = 0;
      for (int i = 0; i < 40; i++) begin
         cyc;
         if (plot === 1'b1) plots++;
         if (draw_done === 1'b1) dones++;
      end
      chk("post_reset_plots", plots, 0);
      chk("post_reset_dones", dones, 0);
      m_y = 7'd56;
      run_draw(0, 0, 1, 57, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
